// File: rtl/systolic_pkg.sv
// Shared constants, drain FSM state type and c_flat unpack helper for the
// 4x4 systolic array and its result drain.
package systolic_pkg;

    localparam int N      = 4;
    localparam int CW     = 33;
    localparam int NUM_PE = N * N;
    localparam int IDX_W  = $clog2(NUM_PE);
    localparam int RC_W   = $clog2(N);

    typedef enum logic {
        IDLE,
        STREAM
    } drain_state_e;

    // Element (r,c) of the flattened PE result bus.
    function automatic logic [CW-1:0] unpack_pe(input logic [NUM_PE*CW-1:0] c_flat,
                                                input int r, input int c);
        return c_flat[(r*N+c)*CW +: CW];
    endfunction

endpackage

// File: rtl/systolic_result_drain.sv
// Snapshots all PE accumulators on capture and streams them out row-major
// over valid/ready, so the array can be reloaded while results drain.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int N  = systolic_pkg::N,
    parameter int CW = systolic_pkg::CW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*N*CW-1:0]    c_flat,
    input  logic                 capture,
    input  logic                 overrun_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_row,
    output logic [$clog2(N)-1:0] out_col,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overrun
);

    localparam int NPE = N * N;
    localparam int IW  = $clog2(NPE);
    localparam int RW  = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPE - 1);

    drain_state_e  state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] rbuf [NPE];
    logic          overrun_q;

    logic hs, at_last, frame_done, load, ovr_set;

    assign hs         = (state_q == STREAM) && out_ready;
    assign at_last    = (idx_q == LAST_IDX);
    assign frame_done = hs && at_last;
    // A capture on the final handshake chains the next frame with no bubble.
    assign load       = capture && ((state_q == IDLE) || frame_done);
    assign ovr_set    = capture && !load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = STREAM;
            STREAM:  if (frame_done && !capture) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  idx_q <= '0;
        else if (load || frame_done) idx_q <= '0;
        else if (hs)                 idx_q <= idx_q + IW'(1);
    end

    // Snapshot storage needs no reset: it is only observed while streaming.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < NPE; i++)
                rbuf[i] <= c_flat[i*CW +: CW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           overrun_q <= 1'b0;
        else if (ovr_set)     overrun_q <= 1'b1;
        else if (overrun_clr) overrun_q <= 1'b0;
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        out_row   = '0;
        out_col   = '0;
        out_last  = 1'b0;
        if (state_q == STREAM) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_data  = rbuf[idx_q];
            out_row   = RW'(32'(idx_q) / N);
            out_col   = RW'(32'(idx_q) % N);
            out_last  = at_last;
        end
    end

    assign overrun = overrun_q;

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
Read-side companion to the 4x4 PE array. It snapshots all N*N accumulator outputs (C_out of each PE) on a capture strobe from the array controller. It then streams them out one word per beat, row-major, over a valid/ready interface to the host/memory writer. It decouples the array from downstream back-pressure so the array can be reset and reloaded while results drain.

Parameters:
N, 4, array dimension (rows = cols = N); N*N results per frame
CW, 33, result width in bits (matches PE C_out)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
c_flat  in  N*N*CW  all PE results; element (r,c) at bits [(r*N+c)*CW +: CW]
capture  in  1  one-cycle strobe: snapshot c_flat this cycle
overrun_clr  in  1  clears the sticky overrun flag
out_valid  out  1  out_data holds a valid result beat
out_ready  in  1  downstream accepts the beat when out_valid & out_ready
out_data  out  CW  result word
out_row  out  $clog2(N)  row index of current beat
out_col  out  $clog2(N)  column index of current beat
out_last  out  1  high with the final beat (r=N-1, c=N-1) of a frame
busy  out  1  frame captured and not yet fully drained
overrun  out  1  sticky: capture arrived while busy and was dropped

Behaviour:
- Reset (rst_n low, async): state=IDLE, idx=0, out_valid=0, busy=0, overrun=0, out_last=0. Buffer contents are don't-care; out_data/out_row/out_col read 0.
- Buffer: N*N x CW registers plus an index register idx (width $clog2(N*N)). out_data=buf[idx], out_row=idx/N, out_col=idx%N. All are driven from registers, with no combinational path from c_flat or out_ready to outputs.
- States: IDLE, STREAM.
- IDLE: out_valid=0, busy=0. If capture: load all N*N words from c_flat, idx<=0, go STREAM. First beat is visible the cycle after capture (latency 1).
- STREAM: out_valid=1, busy=1. On handshake (out_valid & out_ready):
  - idx<N*N-1: idx<=idx+1.
  - idx==N*N-1: frame done.
- No handshake: idx, out_data, out_row, out_col are held stable. Valid must not drop without a handshake.
- out_last = out_valid & (idx==N*N-1).
- Frame done with capture in the same cycle: reload the buffer, idx<=0, stay STREAM. Back-to-back frames have no bubble and no overrun.
- Frame done without capture: go IDLE.
- Capture in STREAM other than on the last handshake: ignored. Buffer is untouched and overrun<=1.
- overrun_clr clears overrun. If overrun_clr and an overrun event occur in the same cycle, the set wins.
- Reset mid-frame: remaining beats are discarded and the block returns to IDLE immediately (async).
- Minimum frame time is N*N cycles with out_ready held high.

Decomposition:
- Shared package systolic_pkg holds:
  - constants N=4, CW=33, NUM_PE=N*N, IDX_W=$clog2(NUM_PE), RC_W=$clog2(N);
  - drain state enum {IDLE, STREAM};
  - a function unpacking (r,c) from c_flat.
- No sub-module is needed; the buffer and FSM stay in one module. The unpack function is reused by the feeder and the testbench.

Test Plan:
- Basic frame: c(r,c)=33'h1_0000_0000+(r*4+c), capture, out_ready=1. Expect 16 beats on consecutive cycles starting 1 cycle after capture. Data ends in ...00..0F, row/col 0,0 -> 3,3, out_last only on beat 16, then busy=0.
- Back-pressure: same frame, toggle out_ready 1,0,0,1,... Expect out_data/row/col stable while out_ready=0, no beat lost or duplicated, and 16 beats total.
- Snapshot isolation: change c_flat to all 33'h0_FFFF_FFFF one cycle after capture. Expect the drained data to still equal the original frame.
- Overrun: capture, then capture again at beat 5. Expect overrun=1, frame 1 unaffected, no second frame. Pulse overrun_clr and expect overrun=0.
- Back-to-back: second capture (values +0x100) in the same cycle as the beat-16 handshake. Expect the next cycle to show beat 0 of frame 2 (0x1_0000_0100), 32 contiguous beats, and overrun=0.
- Async reset: assert rst_n=0 mid-cycle at beat 7. Expect out_valid, busy and overrun to go 0 immediately. After release with no capture, expect out_valid to stay 0.
